// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - synchroniser and tick-based debouncer for active-low switch inputs
//
// Purpose: turns raw, asynchronous, active-low switch pins into clean active-high
// levels plus one-cycle rise/fall pulses. A single shared prescaler produces a
// sample tick; each bit keeps a small count of consecutive ticks on which its
// synchronised input disagreed with the debounced level.
//
// Ports:
//   clk_i    system clock
//   rst_i    synchronous, active-high reset
//   sw_ni    raw pin levels, asynchronous, low = switch on
//   sw_o     debounced level, 1 = on
//   rise_o   one-cycle pulse per bit when sw_o goes 0->1
//   fall_o   one-cycle pulse per bit when sw_o goes 1->0
//   event_o  OR of all rise_o/fall_o bits (interrupt source)
module switch_debounce #(
  parameter int unsigned Width       = 16,
  parameter int unsigned ClkFreq     = 30_000_000,
  parameter int unsigned TickHz      = 1000,
  parameter int unsigned StableTicks = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] sw_ni,
  output logic [Width-1:0] sw_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             event_o
);

  localparam int unsigned TickCycles = ClkFreq / TickHz;
  localparam int unsigned PrescW     = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam int unsigned CntW       = (StableTicks > 0) ? $clog2(StableTicks + 1) : 1;

  localparam logic [PrescW-1:0] PrescLast = PrescW'(TickCycles - 1);
  localparam logic [CntW-1:0]   CntLast   = CntW'(StableTicks - 1);

  if (TickCycles < 2) begin : g_bad_tick_cycles
    $error("switch_debounce: ClkFreq / TickHz must be at least 2");
  end

  if (StableTicks < 1) begin : g_bad_stable_ticks
    $error("switch_debounce: StableTicks must be at least 1");
  end

  // Two-flop synchroniser; inversion happens on entry so everything downstream
  // is active-high.
  logic [Width-1:0] sync1_q;
  logic [Width-1:0] sync_q;

  // Shared prescaler.
  logic [PrescW-1:0] presc_q;
  logic [PrescW-1:0] presc_d;
  logic              tick;

  // Per-bit debounce state.
  logic [Width-1:0] sw_q;
  logic [Width-1:0] sw_d;
  logic [CntW-1:0]  cnt_q [Width];
  logic [CntW-1:0]  cnt_d [Width];

  // Registered edge outputs, aligned with the cycle sw_q shows the new value.
  logic [Width-1:0] rise_q;
  logic [Width-1:0] rise_d;
  logic [Width-1:0] fall_q;
  logic [Width-1:0] fall_d;
  logic             event_q;

  assign tick = (presc_q == PrescLast);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) begin
      presc_d = '0;
    end
  end

  always_comb begin
    sw_d   = sw_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(Width); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == sw_q[i]) begin
        // Any agreement, even for one cycle, restarts the stability count.
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CntLast) begin
          sw_d[i]   = sync_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = sync_q[i];
          fall_d[i] = ~sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync_q  <= '0;
      presc_q <= '0;
      sw_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= 1'b0;
      for (int i = 0; i < int'(Width); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= ~sw_ni;
      sync_q  <= sync1_q;
      presc_q <= presc_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= |(rise_d | fall_d);
      for (int i = 0; i < int'(Width); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_o    = sw_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;

endmodule
